// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
//   Supervises the board PLL from the 48 MHz reference clock. Holds the PLL in
//   reset, waits for a stable synchronized lock, then releases the 250, 166 and
//   25 MHz domain resets in that order. A runtime loss of lock drops all domain
//   resets and restarts the sequence. Too many failed lock attempts park the
//   block in FAULT until rst_n or restart.
//
// Ports
//   clk, rst_n        reference clock, async active-low reset
//   locked_i          PLL LOCK (asynchronous, synchronized internally)
//   restart_i         synchronous pulse, forces a full re-sequence
//   pll_rst_o         active-high PLL reset
//   domain_rst_n_o    [0]=250 MHz, [1]=166 MHz, [2]=25 MHz, active low
//   ready_o           high in RUN
//   fault_o           sticky retry-exhausted flag
//   loss_count_o      runtime lock-loss events, saturating
//   state_o           debug state (0 RESET_PLL,1 WAIT_LOCK,2 RELEASE,3 RUN,4 FAULT)
//
// Optional build macro PLL_PHASE_STEP_EN adds the PLL dynamic phase-step port
//   phase_req_i/phase_sel_i/phase_dir_i in, pll_phasesel_o/pll_phasedir_o/
//   pll_phasestep_o/pll_phaseloadreg_o/phase_busy_o out.
// -----------------------------------------------------------------------------
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES      = 48,
    parameter int LOCK_STABLE_CYCLES  = 4800,
    parameter int LOCK_TIMEOUT_CYCLES = 48000,
    parameter int RELEASE_GAP         = 16,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       locked_i,
    input  logic       restart_i,
`ifdef PLL_PHASE_STEP_EN
    input  logic       phase_req_i,
    input  logic [1:0] phase_sel_i,
    input  logic       phase_dir_i,
    output logic [1:0] pll_phasesel_o,
    output logic       pll_phasedir_o,
    output logic       pll_phasestep_o,
    output logic       pll_phaseloadreg_o,
    output logic       phase_busy_o,
`endif
    output logic       pll_rst_o,
    output logic [2:0] domain_rst_n_o,
    output logic       ready_o,
    output logic       fault_o,
    output logic [7:0] loss_count_o,
    output logic [2:0] state_o
);

    localparam int RST_W = (PLL_RST_CYCLES      > 1) ? $clog2(PLL_RST_CYCLES)      : 1;
    localparam int STB_W = (LOCK_STABLE_CYCLES  > 1) ? $clog2(LOCK_STABLE_CYCLES)  : 1;
    localparam int TMO_W = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
    localparam int GAP_W = (RELEASE_GAP         > 1) ? $clog2(RELEASE_GAP)         : 1;
    localparam int RTY_W = (MAX_RETRIES         > 1) ? $clog2(MAX_RETRIES)         : 1;

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_RELEASE   = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       sync_q;
    logic             lock_s;
    logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
    logic [STB_W-1:0] stb_cnt_q, stb_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [1:0]       step_q, step_d;      // which domain is being released
    logic [RTY_W-1:0] retry_q, retry_d;
    logic [7:0]       loss_q, loss_d;
    logic             pll_rst_q, pll_rst_d;
    logic [2:0]       dom_q, dom_d;
    logic             ready_q, ready_d, fault_q, fault_d;
    logic             lock_lost;

    // Two-flop synchronizer on the asynchronous LOCK input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], locked_i};
    end
    assign lock_s    = sync_q[1];
    assign lock_lost = ((state_q == S_RELEASE) || (state_q == S_RUN)) && !lock_s;

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = '0;
        stb_cnt_d = '0;
        tmo_cnt_d = '0;
        gap_cnt_d = '0;
        step_d    = '0;
        retry_d   = retry_q;
        loss_d    = loss_q;
        unique case (state_q)
            S_RESET_PLL: begin
                if (rst_cnt_q == RST_W'(PLL_RST_CYCLES - 1)) state_d = S_WAIT_LOCK;
                else rst_cnt_d = rst_cnt_q + RST_W'(1);
            end
            S_WAIT_LOCK: begin
                stb_cnt_d = lock_s ? stb_cnt_q + STB_W'(1) : '0;
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                // The stable count reaches its target on this cycle: stable wins.
                if (lock_s && (stb_cnt_q == STB_W'(LOCK_STABLE_CYCLES - 1))) begin
                    state_d = S_RELEASE;
                    retry_d = '0;
                end else if (tmo_cnt_q == TMO_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                    if (int'(retry_q) + 1 == MAX_RETRIES) begin
                        state_d = S_FAULT;
                    end else begin
                        retry_d = retry_q + RTY_W'(1);
                        state_d = S_RESET_PLL;
                    end
                end
            end
            S_RELEASE: begin
                if (!lock_s) begin
                    state_d = S_RESET_PLL;
                end else if (gap_cnt_q == GAP_W'(RELEASE_GAP - 1)) begin
                    if (step_q == 2'd2) state_d = S_RUN;
                    else                step_d  = step_q + 2'd1;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    step_d    = step_q;
                end
            end
            S_RUN: begin
                if (!lock_s) state_d = S_RESET_PLL;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_RESET_PLL;
        endcase

        if (lock_lost && (loss_q != 8'hFF)) loss_d = loss_q + 8'd1;

        if (restart_i) begin
            state_d   = S_RESET_PLL;
            rst_cnt_d = '0;
            stb_cnt_d = '0;
            tmo_cnt_d = '0;
            gap_cnt_d = '0;
            step_d    = '0;
            retry_d   = '0;
            loss_d    = loss_q;
        end

        // Outputs are registered from the next state so the reset pins never glitch.
        pll_rst_d = (state_d == S_RESET_PLL) || (state_d == S_FAULT);
        ready_d   = (state_d == S_RUN);
        fault_d   = (state_d == S_FAULT);
        dom_d     = 3'b000;
        if (state_d == S_RELEASE) dom_d = {step_d == 2'd2, step_d != 2'd0, 1'b1};
        else if (state_d == S_RUN) dom_d = 3'b111;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RESET_PLL;
            rst_cnt_q <= '0;
            stb_cnt_q <= '0;
            tmo_cnt_q <= '0;
            gap_cnt_q <= '0;
            step_q    <= '0;
            retry_q   <= '0;
            loss_q    <= '0;
            pll_rst_q <= 1'b1;
            dom_q     <= 3'b000;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            stb_cnt_q <= stb_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            step_q    <= step_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
            pll_rst_q <= pll_rst_d;
            dom_q     <= dom_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
        end
    end

    assign pll_rst_o      = pll_rst_q;
    assign domain_rst_n_o = dom_q;
    assign ready_o        = ready_q;
    assign fault_o        = fault_q;
    assign loss_count_o   = loss_q;
    assign state_o        = state_q;

`ifdef PLL_PHASE_STEP_EN
    // Phase step: 2 setup cycles, PHASESTEP low for 4, 4 settle cycles (busy = 10).
    logic       ph_busy_q, ph_busy_d;
    logic [3:0] ph_cnt_q, ph_cnt_d;
    logic [1:0] ph_sel_q, ph_sel_d;
    logic       ph_dir_q, ph_dir_d;
    logic       ph_step_q, ph_step_d;
    logic       ph_abort;

    assign ph_abort = restart_i | lock_lost;

    always_comb begin
        ph_busy_d = ph_busy_q;
        ph_cnt_d  = ph_cnt_q;
        ph_sel_d  = ph_sel_q;
        ph_dir_d  = ph_dir_q;
        if (ph_abort || (ph_busy_q && (ph_cnt_q == 4'd9))) begin
            ph_busy_d = 1'b0;
            ph_cnt_d  = 4'd0;
            ph_sel_d  = 2'd0;
            ph_dir_d  = 1'b1;
        end else if (ph_busy_q) begin
            ph_cnt_d  = ph_cnt_q + 4'd1;
        end else if (phase_req_i && (state_q == S_RUN)) begin
            ph_busy_d = 1'b1;
            ph_cnt_d  = 4'd0;
            ph_sel_d  = phase_sel_i;
            ph_dir_d  = phase_dir_i;
        end
        ph_step_d = ~(ph_busy_d && (ph_cnt_d >= 4'd2) && (ph_cnt_d <= 4'd5));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_busy_q <= 1'b0;
            ph_cnt_q  <= 4'd0;
            ph_sel_q  <= 2'd0;
            ph_dir_q  <= 1'b1;
            ph_step_q <= 1'b1;
        end else begin
            ph_busy_q <= ph_busy_d;
            ph_cnt_q  <= ph_cnt_d;
            ph_sel_q  <= ph_sel_d;
            ph_dir_q  <= ph_dir_d;
            ph_step_q <= ph_step_d;
        end
    end

    assign pll_phasesel_o     = ph_sel_q;
    assign pll_phasedir_o     = ph_dir_q;
    assign pll_phasestep_o    = ph_step_q;
    assign pll_phaseloadreg_o = 1'b1;
    assign phase_busy_o       = ph_busy_q;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_sequencer
//   Directed scenarios plus randomized locked/restart traffic. A behavioural
//   model tracks the sequencer as "phase + elapsed cycles in phase" and the
//   expected pins are derived from that every cycle.
// -----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

    localparam int PRC = 4;
    localparam int LSC = 8;
    localparam int LTC = 32;
    localparam int RG  = 2;
    localparam int MR  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       locked = 1'b0;
    logic       restart = 1'b0;
    logic       pll_rst, ready, fault;
    logic [2:0] domain_rst_n, state;
    logic [7:0] loss_count;

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES     (PRC),
        .LOCK_STABLE_CYCLES (LSC),
        .LOCK_TIMEOUT_CYCLES(LTC),
        .RELEASE_GAP        (RG),
        .MAX_RETRIES        (MR)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .locked_i      (locked),
        .restart_i     (restart),
        .pll_rst_o     (pll_rst),
        .domain_rst_n_o(domain_rst_n),
        .ready_o       (ready),
        .fault_o       (fault),
        .loss_count_o  (loss_count),
        .state_o       (state)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Model: phase code, cycles spent in it, run of consecutive synced-high lock,
    // failed attempts, loss events, and the two synchronizer stages.
    int m_st, m_t, m_run, m_ret, m_loss;
    bit m_s1, m_s2;

    function automatic logic [16:0] obs();
        return {state, pll_rst, domain_rst_n, ready, fault, loss_count};
    endfunction

    function automatic logic [16:0] exp_word();
        logic [2:0] d;
        d = 3'b000;
        if (m_st == 2)      d = {m_t >= 2 * RG, m_t >= RG, 1'b1};
        else if (m_st == 3) d = 3'b111;
        return {3'(m_st), (m_st == 0) || (m_st == 4), d, m_st == 3, m_st == 4, 8'(m_loss)};
    endfunction

    task automatic model_edge(input bit lk, input bit rs);
        bit ls;
        ls = m_s2;
        if (rs) begin
            m_st = 0; m_t = 0; m_run = 0; m_ret = 0;
        end else begin
            case (m_st)
                0: if (m_t == PRC - 1) begin m_st = 1; m_t = 0; m_run = 0; end
                   else m_t++;
                1: begin
                    m_run = ls ? m_run + 1 : 0;
                    if (m_run == LSC) begin
                        m_st = 2; m_t = 0; m_ret = 0;
                    end else if (m_t == LTC - 1) begin
                        m_ret++;
                        m_st = (m_ret == MR) ? 4 : 0;
                        m_t  = 0;
                    end else m_t++;
                end
                2, 3: begin
                    if (!ls) begin
                        if (m_loss < 255) m_loss++;
                        m_st = 0; m_t = 0;
                    end else if (m_st == 2) begin
                        if (m_t + 1 == 3 * RG) begin m_st = 3; m_t = 0; end
                        else m_t++;
                    end
                end
                default: ;
            endcase
        end
        m_s2 = m_s1;
        m_s1 = lk;
    endtask

    task automatic step(input bit lk, input bit rs);
        locked  = lk;
        restart = rs;
        @(posedge clk);
        model_edge(lk, rs);
        @(negedge clk);
        cyc++;
        chk("cyc", 32'(obs()), 32'(exp_word()));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; locked = 1'b0; restart = 1'b0;
        @(negedge clk);
        @(negedge clk);
        m_st = 0; m_t = 0; m_run = 0; m_ret = 0; m_loss = 0; m_s1 = 0; m_s2 = 0;
        cyc = 0;
        chk("rst_word", 32'(obs()), 32'(exp_word()));
        chk("rst_pllrst", 32'(pll_rst), 32'd1);
        chk("rst_dom", 32'(domain_rst_n), 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!ready && n < 80) begin step(1'b1, 1'b0); n++; end
        chk(tag, 32'(ready), 32'd1);
    endtask

    initial begin
        // Basic lock and ordered release.
        do_reset();
        for (int i = 0; i < 30; i++) begin
            if (cyc <= 3) chk("s1_pllrst_hi", 32'(pll_rst), 32'd1);
            if (cyc == 4) chk("s1_pllrst_lo", 32'(pll_rst), 32'd0);
            if (cyc == 19) chk("s1_wait", 32'(state), 32'd1);
            if (cyc == 20) chk("s1_rel_entry", 32'(state), 32'd2);
            if (cyc == 20) chk("s1_dom001", 32'(domain_rst_n), 32'b001);
            if (cyc == 22) chk("s1_dom011", 32'(domain_rst_n), 32'b011);
            if (cyc == 24) chk("s1_dom111", 32'(domain_rst_n), 32'b111);
            if (cyc == 25) chk("s1_notready", 32'(ready), 32'd0);
            if (cyc == 26) chk("s1_ready", 32'(ready), 32'd1);
            step(cyc >= 10, 1'b0);
        end

        // Chattering lock: never stable, first timeout back to RESET_PLL.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            if (cyc <= 36) chk("s2_norelease", 32'(state == 3'd2), 32'd0);
            if (cyc == 35) chk("s2_wait", 32'(state), 32'd1);
            if (cyc == 36) chk("s2_retry_rst", 32'(state), 32'd0);
            step((cyc % 5) != 4, 1'b0);
        end

        // No lock: two timeouts then FAULT; restart clears it.
        do_reset();
        for (int i = 0; i < 80; i++) begin
            if (cyc == 71) chk("s3_wait2", 32'(state), 32'd1);
            if (cyc == 72) chk("s3_fault_st", 32'(state), 32'd4);
            if (cyc == 72) chk("s3_fault", 32'(fault), 32'd1);
            step(1'b0, 1'b0);
        end
        chk("s3_fault_pllrst", 32'(pll_rst), 32'd1);
        chk("s3_fault_dom", 32'(domain_rst_n), 32'd0);
        chk("s3_fault_sticky", 32'(fault), 32'd1);
        step(1'b0, 1'b1);
        chk("s4_fault_clr", 32'(fault), 32'd0);
        chk("s4_state_rst", 32'(state), 32'd0);
        wait_ready("s4_relock");

        // Repeated runtime lock loss: 3-cycle drop, saturating loss counter.
        for (int k = 0; k < 300; k++) begin
            step(1'b0, 1'b0);
            step(1'b0, 1'b0);
            step(1'b0, 1'b0);
            if (k < 3) begin
                chk("s5_dom_drop", 32'(domain_rst_n), 32'd0);
                chk("s5_ready_drop", 32'(ready), 32'd0);
            end
            if (k == 0) chk("s5_loss1", 32'(loss_count), 32'd1);
            wait_ready("s5_reseq");
        end
        chk("s5_loss_sat", 32'(loss_count), 32'd255);

        // Random locked / restart traffic.
        for (int r = 0; r < 2; r++) begin
            bit lk;
            do_reset();
            lk = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(15) == 0) lk = ~lk;
                step(lk, $urandom_range(255) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
